rgb565_grayscale_seq_ise: RTL and testbench
===========================================

Name: rgb565_grayscale_seq_ise

Overview:
Multi-cycle custom-instruction unit that converts four packed RGB565 pixels into four 8-bit grayscale values. valueA and valueB each carry two pixels. The result packs the four luma bytes into one 32-bit word. The unit sits on the CPU custom-instruction bus and answers only to its own instruction id. A configurable number of pixels is converted per clock, which lets area be traded against latency. The luma weights are parameters.

Parameters:
customInstructionId, 8'd0, instruction id the unit responds to on iseId.
pixelsPerCycle, 1, number of pixels converted per clock. Legal values are 1, 2 and 4. Conversion count N = 4/pixelsPerCycle.
redWeight, 54, 8-bit unsigned luma weight for red.
greenWeight, 183, 8-bit unsigned luma weight for green.
blueWeight, 19, 8-bit unsigned luma weight for blue.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  custom-instruction start strobe.
iseId  input  8  instruction id of the current custom instruction.
valueA  input  32  pixels P0 = [15:0] and P1 = [31:16].
valueB  input  32  pixels P2 = [15:0] and P3 = [31:16].
done  output  1  one-cycle completion pulse.
result  output  32  packed gray bytes. Byte i = gray(Pi). Zero whenever done = 0.

Behaviour:
- Reset (synchronous): state = IDLE, done = 0, result = 0, internal operand and result registers = 0, pixel counter = 0.
- Reset mid-operation aborts the conversion. No done pulse is produced, and all registers return to their reset values.
- FSM states are IDLE, BUSY and DONE.
- IDLE: on a rising edge where start = 1 and iseId == customInstructionId:
  - latch valueA and valueB;
  - clear the counter;
  - go to BUSY.
  Start with any other iseId is ignored, and done stays 0.
- BUSY: on each edge, convert the next pixelsPerCycle pixels in order P0 to P3 and write their bytes to the internal result register. The counter increments by pixelsPerCycle. After the N-th conversion edge, go to DONE.
- DONE: done = 1 and result = the packed bytes, for exactly one cycle. On the next edge, return to IDLE; done and result go to 0.
- Latency: a start accepted at edge k produces done = 1 in the cycle between edges k+N and k+N+1.
  - N = 4 for pixelsPerCycle = 1.
  - N = 2 for pixelsPerCycle = 2.
  - N = 1 for pixelsPerCycle = 4.
- Start pulses in BUSY or DONE are ignored, whatever the iseId. Latched operands are not disturbed by input changes after acceptance.
- Channel expansion:
  - R8 = {P[15:11], 3'b000}
  - G8 = {P[10:5], 2'b00}
  - B8 = {P[4:0], 3'b000}
- Arithmetic: sum = redWeight*R8 + greenWeight*G8 + blueWeight*B8, computed unsigned at 18 bits with no overflow.
- gray = sum[17:8]. If that value exceeds 255, gray saturates to 8'hFF; otherwise gray = sum[15:8]. Saturation only matters if the weights sum to more than 256.
- Outputs are registered, with no combinational path from inputs to done or result.

Test Plan:
1. Reset with pixelsPerCycle = 1, then apply start = 1, iseId = 13 (customInstructionId = 13), valueA = 32'hF800_07E0, valueB = 32'h001F_FFFF. Required: done is low for 3 cycles, then high for exactly 1 cycle, 4 cycles after acceptance, with result = 32'h12FA_34B4. In the next cycle, done = 0 and result = 0.
2. Repeat scenario 1 with pixelsPerCycle = 2 and with pixelsPerCycle = 4. Required: the same result 32'h12FA_34B4, with done arriving 2 and 1 cycles after acceptance respectively.
3. Apply start = 1 with iseId = 47, then start = 0 with iseId = 13, each with valueA = valueB = 32'hFFFF_FFFF. Required: done = 0 and result = 0 for 10 cycles.
4. Accept a start with all pixels 16'hFFFF. During BUSY, assert a second start with iseId = 13 and valueA = 0. Required: a single done pulse with result = 32'hFAFA_FAFA, and no second pulse.
5. Accept a start, then assert reset on the second BUSY cycle. Required: no done pulse, and result = 0. A fresh start with valueA = valueB = 0 then gives done after N cycles with result = 0.
6. Back-to-back operation: issue a new start in the cycle after done. Required: it is accepted from IDLE and produces a correct second pulse, e.g. valueA = 32'h0000_F800 gives result = 32'h0000_0034.

Source files
------------

// File: rtl/rgb565_grayscale_seq_ise.sv
// Custom-instruction unit: converts four packed RGB565 pixels to four 8-bit luma bytes,
// handling pixelsPerCycle pixels per clock so area can be traded against latency.
module rgb565_grayscale_seq_ise #(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         pixelsPerCycle      = 1,
    parameter logic [7:0] redWeight           = 8'd54,
    parameter logic [7:0] greenWeight         = 8'd183,
    parameter logic [7:0] blueWeight          = 8'd19
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [2:0] STEP = 3'(pixelsPerCycle);

    state_t      state_q, state_d;
    logic [63:0] operand_q, operand_d;
    logic [31:0] gray_q, gray_d;
    logic [2:0]  count_q, count_d;
    logic        done_d;
    logic [31:0] result_d;
    logic [1:0]  pixel_idx;

    // Weighted sum fits in 18 bits (3 * 255 * 252 < 2^18); saturate when bits above 15 are set.
    function automatic logic [7:0] to_gray(input logic [15:0] pixel);
        logic [17:0] sum;
        sum = 18'(redWeight)   * 18'({pixel[15:11], 3'b000})
            + 18'(greenWeight) * 18'({pixel[10:5],  2'b00})
            + 18'(blueWeight)  * 18'({pixel[4:0],   3'b000});
        return (sum[17:16] != 2'b00) ? 8'hFF : sum[15:8];
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            operand_q <= '0;
            gray_q    <= '0;
            count_q   <= '0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            gray_q    <= gray_d;
            count_q   <= count_d;
            done      <= done_d;
            result    <= result_d;
        end
    end

    // done/result are computed here but only ever leave the block through registers.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        gray_d    = gray_q;
        count_d   = count_q;
        done_d    = 1'b0;
        result_d  = '0;
        pixel_idx = 2'b00;
        case (state_q)
            IDLE: begin
                if (start && (iseId == customInstructionId)) begin
                    operand_d = {valueB, valueA};
                    gray_d    = '0;
                    count_d   = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                for (int j = 0; j < pixelsPerCycle; j++) begin
                    pixel_idx = count_q[1:0] + 2'(j);
                    gray_d[{pixel_idx, 3'b000} +: 8] = to_gray(operand_q[{pixel_idx, 4'b0000} +: 16]);
                end
                count_d = count_q + STEP;
                if (count_d == 3'd4) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = gray_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rgb565_grayscale_seq_ise.sv
// Bench for rgb565_grayscale_seq_ise: three instances (1, 2, 4 pixels/cycle) share stimulus
// and are checked every cycle against a timing/arithmetic reference model.
module tb_rgb565_grayscale_seq_ise;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  iseId = 8'd0;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic        done_w [3];
    logic [31:0] result_w [3];

    int          assertCount = 0;
    int          failCount = 0;
    longint      edgeNo = 0;
    int          latency [3] = '{4, 2, 1};
    longint      freeAt [3];
    longint      doneEdge [3];
    bit          active [3];
    logic [31:0] expResult [3];
    int          pulses [3];
    logic [31:0] captured [3];

    always #5 clock = ~clock;

    rgb565_grayscale_seq_ise #(.customInstructionId(8'd13), .pixelsPerCycle(1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[0]), .result(result_w[0]));
    rgb565_grayscale_seq_ise #(.customInstructionId(8'd13), .pixelsPerCycle(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[1]), .result(result_w[1]));
    rgb565_grayscale_seq_ise #(.customInstructionId(8'd13), .pixelsPerCycle(4)) dut3 (
        .clock(clock), .reset(reset), .start(start), .iseId(iseId),
        .valueA(valueA), .valueB(valueB), .done(done_w[2]), .result(result_w[2]));

    function automatic int refGray(input logic [15:0] p);
        int r, g, b, v;
        r = int'(p[15:11]) * 8;
        g = int'(p[10:5]) * 4;
        b = int'(p[4:0]) * 8;
        v = (54 * r + 183 * g + 19 * b) / 256;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [31:0] refPack(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] w;
        w[7:0]   = 8'(refGray(a[15:0]));
        w[15:8]  = 8'(refGray(a[31:16]));
        w[23:16] = 8'(refGray(b[15:0]));
        w[31:24] = 8'(refGray(b[31:16]));
        return w;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit expDone;
        for (int i = 0; i < 3; i++) begin
            expDone = active[i] && (edgeNo == doneEdge[i]);
            checkValue($sformatf("inst%0d_done@%0d", i, edgeNo), 32'(done_w[i]), 32'(expDone));
            checkValue($sformatf("inst%0d_result@%0d", i, edgeNo), result_w[i],
                       expDone ? expResult[i] : 32'h0);
            if (done_w[i] === 1'b1) begin
                pulses[i]++;
                captured[i] = result_w[i];
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then check at the falling edge.
    task automatic applyStimulus(input bit s, input logic [7:0] id, input logic [31:0] a,
                                 input logic [31:0] b, input bit r);
        reset = r;
        start = s;
        iseId = id;
        valueA = a;
        valueB = b;
        @(posedge clock);
        edgeNo++;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                active[i] = 1'b0;
                freeAt[i] = edgeNo + 1;
            end else if (s && id == 8'd13 && edgeNo >= freeAt[i]) begin
                active[i]    = 1'b1;
                doneEdge[i]  = edgeNo + latency[i];
                expResult[i] = refPack(a, b);
                freeAt[i]    = edgeNo + latency[i] + 2;
            end
        end
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idle(input int cycles);
        for (int c = 0; c < cycles; c++) applyStimulus(1'b0, 8'd13, '0, '0, 1'b0);
    endtask

    task automatic clearPulses();
        for (int i = 0; i < 3; i++) begin
            pulses[i] = 0;
            captured[i] = '0;
        end
    endtask

    task automatic checkPulses(input string tag, input int expCount, input logic [31:0] expWord);
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("%s_inst%0d_pulses", tag, i), 32'(pulses[i]), 32'(expCount));
            checkValue($sformatf("%s_inst%0d_word", tag, i), captured[i], expWord);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            active[i] = 1'b0;
            freeAt[i] = 0;
            doneEdge[i] = 0;
            expResult[i] = '0;
        end
        clearPulses();
        @(negedge clock);
        applyStimulus(1'b0, 8'd0, '0, '0, 1'b1);
        applyStimulus(1'b0, 8'd0, '0, '0, 1'b1);

        $display("[TB] known-answer conversion at all three widths");
        clearPulses();
        applyStimulus(1'b1, 8'd13, 32'hF800_07E0, 32'h001F_FFFF, 1'b0);
        idle(6);
        checkPulses("known", 1, 32'h12FA_34B4);

        $display("[TB] foreign instruction id is ignored");
        clearPulses();
        applyStimulus(1'b1, 8'd47, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 8'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        checkPulses("foreign", 0, 32'h0);

        $display("[TB] start while busy is ignored");
        clearPulses();
        applyStimulus(1'b1, 8'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 8'd13, 32'h0, 32'hFFFF_FFFF, 1'b0);
        idle(6);
        checkPulses("busy_start", 1, 32'hFAFA_FAFA);

        $display("[TB] reset aborts a conversion");
        applyStimulus(1'b1, 8'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 8'd13, '0, '0, 1'b0);
        clearPulses();
        applyStimulus(1'b0, 8'd13, '0, '0, 1'b1);
        idle(6);
        checkPulses("abort", 0, 32'h0);
        clearPulses();
        applyStimulus(1'b1, 8'd13, 32'h0, 32'h0, 1'b0);
        idle(6);
        checkPulses("after_abort", 1, 32'h0);

        $display("[TB] back-to-back starts");
        clearPulses();
        for (int c = 0; c < 12; c++) applyStimulus(1'b1, 8'd13, 32'h0000_F800, 32'h0, 1'b0);
        idle(6);
        for (int i = 0; i < 3; i++) begin
            checkValue($sformatf("b2b_inst%0d_word", i), captured[i], 32'h0000_0034);
            checkValue($sformatf("b2b_inst%0d_multi", i), 32'(pulses[i] >= 2), 32'h1);
        end

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd13,
                          $urandom, $urandom,
                          ($urandom_range(0, 39) == 0));
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
